// File: rtl/omnivision_spi_frame_ctrl_if.sv
// Transmitter-side bundle of the frame sequencer: frame/line valid, pixel data
// and the latched frame geometry the transmitter puts in its header.
interface omnivision_spi_frame_ctrl_if #(
    parameter int DATA_WIDTH = 10
);
    logic                  fv;
    logic                  lv;
    logic [DATA_WIDTH-1:0] data;
    logic [15:0]           num_rows;
    logic [15:0]           num_cols;

    modport master (output fv, lv, data, num_rows, num_cols);
    modport slave  (input  fv, lv, data, num_rows, num_cols);
endinterface

// File: rtl/omnivision_spi_frame_ctrl.sv
// Frame/line timing generator for the Omnivision serial transmitter.
// Optional OMNIVISION_FRAME_CTRL_TEST_PATTERN_EN replaces pix_in with row+col.
module omnivision_spi_frame_ctrl #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                    pixclk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [15:0]             cfg_rows,
    input  logic [15:0]             cfg_cols,
    input  logic [7:0]              cfg_header,
    input  logic [15:0]             cfg_hblank,
    input  logic [15:0]             cfg_vblank,
    input  logic [7:0]              cfg_frames,
    input  logic [DATA_WIDTH-1:0]   pix_in,
    omnivision_spi_frame_ctrl_if.master tx,
    output logic [15:0]             row,
    output logic [15:0]             col,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    cfg_err
);
    typedef enum logic [2:0] {IDLE, HEADER, LINE, HBLANK, VBLANK} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_row_cnt, w_row_nxt;
    logic [7:0]  r_frames_left, w_frames_nxt;
    logic        w_latch, w_err;

    logic [15:0] r_rows, r_cols, r_hb, r_vb;
    logic [7:0]  r_hdr;

    logic        r_fv, r_lv, r_busy, r_frame_done, r_cfg_err;
    logic [15:0] r_row, r_col, r_num_rows, r_num_cols;

    logic        w_cfg_ok;
    logic [15:0] w_h_eff, w_hb_eff, w_vb_eff;

    assign w_cfg_ok = (cfg_rows != 16'd0) && (cfg_cols != 16'd0);
    // Header must cover the transmitter's 8-byte frame header.
    assign w_h_eff  = {8'd0, (r_hdr < 8'd8) ? 8'd8 : r_hdr};
    assign w_hb_eff = (r_hb == 16'd0) ? 16'd1 : r_hb;
    assign w_vb_eff = (r_vb == 16'd0) ? 16'd1 : r_vb;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_row_nxt    = r_row_cnt;
        w_frames_nxt = r_frames_left;
        w_latch      = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    if (w_cfg_ok) begin
                        w_latch      = 1'b1;
                        w_frames_nxt = cfg_frames;
                        w_cnt_nxt    = 16'd0;
                        w_state_nxt  = HEADER;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (r_cnt == w_h_eff - 16'd1) begin
                    w_cnt_nxt   = 16'd0;
                    w_row_nxt   = 16'd0;
                    w_state_nxt = LINE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            LINE: begin
                if (r_cnt == r_cols - 16'd1) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = (r_row_cnt == r_rows - 16'd1) ? VBLANK : HBLANK;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            HBLANK: begin
                if (r_cnt == w_hb_eff - 16'd1) begin
                    w_cnt_nxt   = 16'd0;
                    w_row_nxt   = r_row_cnt + 16'd1;
                    w_state_nxt = LINE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            VBLANK: begin
                if (r_cnt == w_vb_eff - 16'd1) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = IDLE;
                    // frames_left of 0 marks continuous mode and is never decremented.
                    if (enable && (r_frames_left == 8'd0 || r_frames_left > 8'd1)) begin
                        if (w_cfg_ok) begin
                            w_latch     = 1'b1;
                            w_state_nxt = HEADER;
                            if (r_frames_left != 8'd0)
                                w_frames_nxt = r_frames_left - 8'd1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= 16'd0;
            r_row_cnt     <= 16'd0;
            r_frames_left <= 8'd0;
            r_rows        <= 16'd0;
            r_cols        <= 16'd0;
            r_hdr         <= 8'd0;
            r_hb          <= 16'd0;
            r_vb          <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_row_cnt     <= w_row_nxt;
            r_frames_left <= w_frames_nxt;
            if (w_latch) begin
                r_rows <= cfg_rows;
                r_cols <= cfg_cols;
                r_hdr  <= cfg_header;
                r_hb   <= cfg_hblank;
                r_vb   <= cfg_vblank;
            end
        end
    end

    // Outputs follow the state register by one cycle so every port is a flop.
    always_ff @(posedge pixclk) begin
        if (reset) begin
            r_fv         <= 1'b0;
            r_lv         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_row        <= 16'd0;
            r_col        <= 16'd0;
            r_num_rows   <= 16'd0;
            r_num_cols   <= 16'd0;
        end else begin
            r_fv         <= (r_state == HEADER) || (r_state == LINE) || (r_state == HBLANK);
            r_lv         <= (r_state == LINE);
            r_busy       <= (r_state != IDLE);
            r_frame_done <= (r_state == VBLANK) && (r_cnt == 16'd0);
            r_cfg_err    <= w_err;
            r_row        <= (r_state == LINE) ? r_row_cnt : 16'd0;
            r_col        <= (r_state == LINE) ? r_cnt : 16'd0;
            if (r_state == HEADER) begin
                r_num_rows <= r_rows;
                r_num_cols <= r_cols;
            end
        end
    end

`ifdef OMNIVISION_FRAME_CTRL_TEST_PATTERN_EN
    logic [DATA_WIDTH-1:0] r_data;
    logic [15:0]           w_sum;
    assign w_sum = r_row_cnt + r_cnt;

    always_ff @(posedge pixclk) begin
        if (reset)
            r_data <= '0;
        else
            r_data <= (r_state == LINE) ? DATA_WIDTH'(w_sum) : '0;
    end
    assign tx.data = r_data;
`else
    assign tx.data = r_lv ? pix_in : '0;
`endif

    assign tx.fv       = r_fv;
    assign tx.lv       = r_lv;
    assign tx.num_rows = r_num_rows;
    assign tx.num_cols = r_num_cols;
    assign row         = r_row;
    assign col         = r_col;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign cfg_err     = r_cfg_err;
endmodule
